// File: rtl/event_irq_ctrl.sv
// Event interrupt controller: edge/level event sources, pend/enable/mode registers, claim/complete FSM, Avalon-MM slave.
// Optional input synchroniser enabled by defining EVENT_IRQ_SYNC_EN.
module event_irq_ctrl #(
    parameter int ADDR_SEL_BITS = 0,
    parameter int ADDR_BLOCK    = 0,
    parameter int NUM_SRC       = 8
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic [NUM_SRC-1:0]        i_Src,
    input  logic                      i_SlaveSel,
    input  logic [29-ADDR_SEL_BITS:0] i_RegAddr,
    input  logic [3:0]                i_AV_ByteEn,
    input  logic                      i_AV_Read,
    input  logic                      i_AV_Write,
    output logic [31:0]               o_AV_ReadData,
    input  logic [31:0]               i_AV_WriteData,
    output logic                      o_AV_WaitRequest,
    output logic                      o_Irq
);

    localparam int AW = 30 - ADDR_SEL_BITS;
    localparam logic [5:0] NSRC6 = 6'(NUM_SRC);

    if (NUM_SRC < 1 || NUM_SRC > 32 || ADDR_BLOCK < 0) begin : g_bad_cfg
        $error("event_irq_ctrl: NUM_SRC must be 1..32 and ADDR_BLOCK non-negative");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        CLAIMED = 1'b1
    } state_t;

    state_t r_State, state_nxt;

    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] r_SrcQ, r_SrcP, r_Edge;
    logic [NUM_SRC-1:0] r_Pend, r_Enable, r_Mode;
    logic [NUM_SRC-1:0] pend_nxt, pend_clr, claim_clr, active, bmask, wbits;
    logic [31:0]        bmask32, wmask32, rd_mux;
    logic [1:0]         r_Prime;
    logic [4:0]         win_idx;
    logic               win_found;
    logic               acc_rd, acc_wr;
    logic               sel_pend, sel_enable, sel_mode, sel_claim, sel_status;
    logic               claim_rd, claim_done, irq_nxt;
    logic               unused_wdata;

`ifdef EVENT_IRQ_SYNC_EN
    localparam logic [1:0] PRIME_CYC = 2'd3;
    logic [NUM_SRC-1:0] r_Sync1, r_Sync2;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Sync1 <= '0;
            r_Sync2 <= '0;
        end else begin
            r_Sync1 <= i_Src;
            r_Sync2 <= r_Sync1;
        end
    end

    assign src_in = r_Sync2;
`else
    localparam logic [1:0] PRIME_CYC = 2'd1;
    assign src_in = i_Src;
`endif

    assign o_AV_WaitRequest = 1'b0;

    assign acc_rd     = i_SlaveSel & i_AV_Read;
    assign acc_wr     = i_SlaveSel & i_AV_Write;
    assign sel_pend   = (i_RegAddr == AW'(0));
    assign sel_enable = (i_RegAddr == AW'(1));
    assign sel_mode   = (i_RegAddr == AW'(2));
    assign sel_claim  = (i_RegAddr == AW'(3));
    assign sel_status = (i_RegAddr == AW'(4));

    assign bmask32 = {{8{i_AV_ByteEn[3]}}, {8{i_AV_ByteEn[2]}},
                      {8{i_AV_ByteEn[1]}}, {8{i_AV_ByteEn[0]}}};
    assign wmask32 = i_AV_WriteData & bmask32;
    assign bmask   = bmask32[NUM_SRC-1:0];
    assign wbits   = wmask32[NUM_SRC-1:0];
    assign unused_wdata = ^{i_AV_WriteData, bmask32};

    // Until the pipeline holds real samples, r_SrcP tracks r_SrcQ so a source
    // already high when reset releases is not seen as a rising edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_SrcQ  <= '0;
            r_SrcP  <= '0;
            r_Edge  <= '0;
            r_Prime <= '0;
        end else begin
            r_SrcQ <= src_in;
            r_SrcP <= (r_Prime != PRIME_CYC) ? src_in : r_SrcQ;
            r_Edge <= r_SrcQ & ~r_SrcP;
            if (r_Prime != PRIME_CYC) begin
                r_Prime <= r_Prime + 2'd1;
            end
        end
    end

    assign active = r_Pend & r_Enable;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (active[i] && !win_found) begin
                win_found = 1'b1;
                win_idx   = 5'(i);
            end
        end
    end

    assign claim_rd   = acc_rd & sel_claim & (r_State == IDLE) & win_found;
    assign claim_done = acc_wr & sel_claim & (r_State == CLAIMED);
    assign claim_clr  = claim_rd ? (NUM_SRC'(1) << win_idx) : '0;
    assign pend_clr   = ((acc_wr & sel_pend) ? wbits : '0) | claim_clr;

    // Registered edge pulse sets after the clear, so a same-cycle set wins.
    assign pend_nxt = (r_Mode & r_SrcQ) | (~r_Mode & ((r_Pend & ~pend_clr) | r_Edge));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Pend   <= '0;
            r_Enable <= '0;
            r_Mode   <= '0;
        end else begin
            r_Pend <= pend_nxt;
            if (acc_wr && sel_enable) begin
                r_Enable <= (r_Enable & ~bmask) | wbits;
            end
            if (acc_wr && sel_mode) begin
                r_Mode <= (r_Mode & ~bmask) | wbits;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State <= IDLE;
        end else begin
            r_State <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = r_State;
        case (r_State)
            IDLE:    if (claim_rd) state_nxt = CLAIMED;
            CLAIMED: if (claim_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq_nxt = (state_nxt == IDLE) && (active != '0);
    end

    always_comb begin
        rd_mux = '0;
        if (sel_pend) begin
            rd_mux = 32'(r_Pend);
        end else if (sel_enable) begin
            rd_mux = 32'(r_Enable);
        end else if (sel_mode) begin
            rd_mux = 32'(r_Mode);
        end else if (sel_claim) begin
            if (r_State == IDLE && win_found) begin
                rd_mux = 32'(win_idx) + 32'd1;
            end
        end else if (sel_status) begin
            rd_mux = {23'b0, (r_State == CLAIMED), 2'b0, NSRC6};
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_AV_ReadData <= '0;
            o_Irq         <= 1'b0;
        end else begin
            o_AV_ReadData <= acc_rd ? rd_mux : '0;
            o_Irq         <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_event_irq_ctrl.sv
// Self-checking bench for event_irq_ctrl: scoreboard of expected read data
// plus direct checks on o_Irq timing and asynchronous reset.
module tb_event_irq_ctrl;

    localparam int N = 8;
`ifdef EVENT_IRQ_SYNC_EN
    localparam int IRQ_LAT = 5;
`else
    localparam int IRQ_LAT = 3;
`endif
    localparam logic [29:0] A_PEND   = 30'd0;
    localparam logic [29:0] A_ENABLE = 30'd1;
    localparam logic [29:0] A_MODE   = 30'd2;
    localparam logic [29:0] A_CLAIM  = 30'd3;
    localparam logic [29:0] A_STATUS = 30'd4;

    logic          i_Clk = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic [N-1:0]  i_Src = '0;
    logic          i_SlaveSel = 1'b0;
    logic [29:0]   i_RegAddr = '0;
    logic [3:0]    i_AV_ByteEn = '0;
    logic          i_AV_Read = 1'b0;
    logic          i_AV_Write = 1'b0;
    logic [31:0]   o_AV_ReadData;
    logic [31:0]   i_AV_WriteData = '0;
    logic          o_AV_WaitRequest;
    logic          o_Irq;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    event_irq_ctrl #(
        .ADDR_SEL_BITS(0),
        .ADDR_BLOCK(0),
        .NUM_SRC(N)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst_n(i_Rst_n),
        .i_Src(i_Src),
        .i_SlaveSel(i_SlaveSel),
        .i_RegAddr(i_RegAddr),
        .i_AV_ByteEn(i_AV_ByteEn),
        .i_AV_Read(i_AV_Read),
        .i_AV_Write(i_AV_Write),
        .o_AV_ReadData(o_AV_ReadData),
        .i_AV_WriteData(i_AV_WriteData),
        .o_AV_WaitRequest(o_AV_WaitRequest),
        .o_Irq(o_Irq)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    // All bus operations start and end 1 ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        i_SlaveSel = 1'b1; i_AV_Write = 1'b1; i_RegAddr = a; i_AV_WriteData = d; i_AV_ByteEn = be;
        @(posedge i_Clk);
        #1;
        i_SlaveSel = 1'b0; i_AV_Write = 1'b0; i_AV_WriteData = '0; i_AV_ByteEn = '0;
    endtask

    task automatic bus_read(input logic [29:0] a, output logic [31:0] d);
        i_SlaveSel = 1'b1; i_AV_Read = 1'b1; i_RegAddr = a; i_AV_ByteEn = 4'hF;
        @(posedge i_Clk);
        #1;
        i_SlaveSel = 1'b0; i_AV_Read = 1'b0; i_AV_ByteEn = '0;
        d = o_AV_ReadData;
    endtask

    task automatic pulse_src(input logic [N-1:0] v);
        i_Src = v;
        @(posedge i_Clk);
        #1;
        i_Src = '0;
    endtask

    task automatic test_reset;
        logic [29:0] addrs [6] = '{A_PEND, A_ENABLE, A_MODE, A_CLAIM, A_STATUS, 30'd7};
        logic [31:0] exps  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'h0};
        logic [31:0] rd, e;
        idle(3);
        n_cmp++;
        if (o_Irq !== 1'b0 || o_AV_ReadData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold: irq=%b rdata=%h, want 0/0", o_Irq, o_AV_ReadData);
        end
        i_Rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 6; i++) exp_q.push_back(exps[i]);
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], rd);
            e = exp_q.pop_front();
            n_cmp++;
            if (rd !== e) begin
                n_fail++;
                $display("FAIL reset_reg[%0d]: read %h, want %h", addrs[i], rd, e);
            end
        end
        // Read strobe without slave select returns zero.
        i_AV_Read = 1'b1; i_RegAddr = A_STATUS;
        idle(1);
        i_AV_Read = 1'b0;
        n_cmp++;
        if (o_AV_ReadData !== 32'h0 || o_AV_WaitRequest !== 1'b0) begin
            n_fail++;
            $display("FAIL unselected_read: rdata=%h wait=%b, want 0/0", o_AV_ReadData, o_AV_WaitRequest);
        end
    endtask

    task automatic test_edge_irq;
        logic [31:0] rd, e;
        bus_write(A_ENABLE, 32'h1, 4'hF);
        pulse_src(8'h01);
        for (int c = 0; c <= IRQ_LAT; c++) begin
            if (c > 0) idle(1);
            n_cmp++;
            if (o_Irq !== (c >= IRQ_LAT)) begin
                n_fail++;
                $display("FAIL irq_latency[k+%0d]: irq=%b, want %b", c, o_Irq, (c >= IRQ_LAT));
            end
        end
        exp_q.push_back(32'h1);
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL edge_pend: read %h, want %h", rd, e); end
        bus_write(A_PEND, 32'h1, 4'h0);
        exp_q.push_back(32'h1);
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL w1c_no_byteen: read %h, want %h", rd, e); end
        bus_write(A_PEND, 32'h1, 4'h1);
        idle(1);
        n_cmp++;
        if (o_Irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_drop: irq=%b, want 0", o_Irq); end
        pulse_src(8'h01);
        idle(IRQ_LAT + 1);
        bus_write(A_ENABLE, 32'h0, 4'hF);
        idle(1);
        n_cmp++;
        if (o_Irq !== 1'b0) begin n_fail++; $display("FAIL disable_irq_drop: irq=%b, want 0", o_Irq); end
        exp_q.push_back(32'h1);
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL disabled_pend_kept: read %h, want %h", rd, e); end
        bus_write(A_PEND, 32'hFF, 4'hF);
    endtask

    task automatic test_claim;
        logic [31:0] rd, e;
        bus_write(A_ENABLE, 32'hFF, 4'hF);
        pulse_src(8'h24);
        idle(IRQ_LAT + 1);
        n_cmp++;
        if (o_Irq !== 1'b1) begin n_fail++; $display("FAIL claim_irq_pre: irq=%b, want 1", o_Irq); end
        exp_q.push_back(32'd3);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h108);
        exp_q.push_back(32'd0);
        bus_read(A_CLAIM, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL claim_first: read %h, want %h", rd, e); end
        n_cmp++;
        if (o_Irq !== 1'b0) begin n_fail++; $display("FAIL claimed_irq: irq=%b, want 0", o_Irq); end
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL claim_pend: read %h, want %h", rd, e); end
        bus_read(A_STATUS, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL claimed_status: read %h, want %h", rd, e); end
        bus_read(A_CLAIM, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL claim_while_claimed: read %h, want %h", rd, e); end
        bus_write(A_CLAIM, 32'h0, 4'h1);
        n_cmp++;
        if (o_Irq !== 1'b1) begin n_fail++; $display("FAIL complete_irq: irq=%b, want 1", o_Irq); end
        exp_q.push_back(32'd6);
        bus_read(A_CLAIM, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL claim_second: read %h, want %h", rd, e); end
        bus_write(A_CLAIM, 32'h0, 4'h8);
        bus_write(A_CLAIM, 32'h0, 4'hF);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h8);
        bus_read(A_CLAIM, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL claim_none: read %h, want %h", rd, e); end
        bus_read(A_STATUS, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL idle_status: read %h, want %h", rd, e); end
    endtask

    task automatic test_set_beats_clear;
        logic [31:0] rd, e;
        bus_write(A_ENABLE, 32'h02, 4'hF);
        pulse_src(8'h02);
        idle(IRQ_LAT - 2);
        bus_write(A_PEND, 32'h02, 4'hF);
        exp_q.push_back(32'h02);
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL set_beats_clear: read %h, want %h", rd, e); end
        bus_write(A_PEND, 32'h02, 4'hF);
        exp_q.push_back(32'h00);
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL later_w1c: read %h, want %h", rd, e); end
    endtask

    task automatic test_level;
        logic [31:0] rd, e;
        bus_write(A_MODE, 32'h04, 4'hF);
        bus_write(A_ENABLE, 32'h04, 4'hF);
        i_Src = 8'h04;
        idle(IRQ_LAT + 2);
        n_cmp++;
        if (o_Irq !== 1'b1) begin n_fail++; $display("FAIL level_irq: irq=%b, want 1", o_Irq); end
        exp_q.push_back(32'h04);
        exp_q.push_back(32'h04);
        exp_q.push_back(32'h04);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'h04);
        bus_read(A_MODE, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL mode_read: read %h, want %h", rd, e); end
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL level_pend: read %h, want %h", rd, e); end
        bus_write(A_PEND, 32'h04, 4'hF);
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL level_w1c: read %h, want %h", rd, e); end
        bus_read(A_CLAIM, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL level_claim: read %h, want %h", rd, e); end
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL level_claim_pend: read %h, want %h", rd, e); end
        bus_write(A_CLAIM, 32'h0, 4'h2);
        i_Src = '0;
        idle(IRQ_LAT + 2);
        exp_q.push_back(32'h00);
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e || o_Irq !== 1'b0) begin
            n_fail++;
            $display("FAIL level_drop: pend %h irq %b, want %h/0", rd, o_Irq, e);
        end
        bus_write(A_ENABLE, 32'hFFFF_FFFF, 4'b1110);
        exp_q.push_back(32'h04);
        bus_read(A_ENABLE, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL enable_byteen: read %h, want %h", rd, e); end
        bus_write(A_ENABLE, 32'hFFFF_FFFF, 4'b0001);
        exp_q.push_back(32'hFF);
        bus_read(A_ENABLE, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL enable_width: read %h, want %h", rd, e); end
        bus_write(A_ENABLE, 32'h0, 4'hF);
        bus_write(A_MODE, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid_claim;
        logic [29:0] addrs [4] = '{A_PEND, A_ENABLE, A_MODE, A_STATUS};
        logic [31:0] exps  [4] = '{32'h0, 32'h0, 32'h0, 32'h8};
        logic [31:0] rd, e;
        bus_write(A_MODE, 32'hFF, 4'hF);
        bus_write(A_ENABLE, 32'hFF, 4'hF);
        i_Src = 8'hFF;
        idle(IRQ_LAT + 2);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'hFF);
        bus_read(A_CLAIM, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL rst_claim: read %h, want %h", rd, e); end
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin n_fail++; $display("FAIL rst_pend_full: read %h, want %h", rd, e); end
        #2 i_Rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_AV_ReadData !== 32'h0 || o_Irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_claimed: rdata=%h irq=%b, want 0/0", o_AV_ReadData, o_Irq);
        end
        idle(2);
        i_Rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) exp_q.push_back(exps[i]);
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], rd);
            e = exp_q.pop_front();
            n_cmp++;
            if (rd !== e) begin
                n_fail++;
                $display("FAIL post_reset_reg[%0d]: read %h, want %h", addrs[i], rd, e);
            end
        end
        bus_write(A_ENABLE, 32'hFF, 4'hF);
        idle(IRQ_LAT + 2);
        exp_q.push_back(32'h0);
        bus_read(A_PEND, rd);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e || o_Irq !== 1'b0) begin
            n_fail++;
            $display("FAIL held_src_no_edge: pend %h irq %b, want %h/0", rd, o_Irq, e);
        end
        bus_write(A_MODE, 32'h01, 4'hF);
        idle(3);
        n_cmp++;
        if (o_Irq !== 1'b1) begin n_fail++; $display("FAIL level_after_reset: irq=%b, want 1", o_Irq); end
        #2 i_Rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_Irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq: irq=%b, want 0", o_Irq); end
        idle(1);
        i_Src = '0;
        i_Rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_edge_irq();
        test_claim();
        test_set_beats_clear();
        test_level();
        test_reset_mid_claim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/event_irq_ctrl.md
EVENT_IRQ_CTRL -- requirements
Module: event_irq_ctrl

Interface
REQ-001 Parameter ADDR_SEL_BITS, default 0: number of upper address bits consumed by the bus decoder; sets i_RegAddr width.
REQ-002 Parameter ADDR_BLOCK, default 0: block index in the peripheral map; carried only, no functional effect.
REQ-003 Parameter NUM_SRC, default 8, legal 1..32: number of event sources.
REQ-004 i_Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_Src  input  NUM_SRC  event lines from peripherals, e.g. Counter overflow flag; may be asynchronous.
REQ-007 i_SlaveSel  input  1  Avalon slave select.
REQ-008 i_RegAddr  input  30-ADDR_SEL_BITS  word register address.
REQ-009 i_AV_ByteEn  input  4  byte enables.
REQ-010 i_AV_Read / i_AV_Write  input  1 each  Avalon read / write strobes.
REQ-011 o_AV_ReadData  output  32  registered read data.
REQ-012 i_AV_WriteData  input  32  write data.
REQ-013 o_AV_WaitRequest  output  1  tied 0.
REQ-014 o_Irq  output  1  registered interrupt request to CPU.

Function
REQ-015 Register map (word addresses): 0 PEND, 1 ENABLE (RW), 2 MODE (RW; bit=1 level, 0 rising-edge), 3 CLAIM, 4 STATUS; other addresses read 0, ignore writes; bits at or above NUM_SRC read 0.
REQ-016 Bus access only when i_SlaveSel=1; o_AV_ReadData = selected register one cycle after i_AV_Read, else 0 that cycle.
REQ-017 Source path: i_Src registered into r_SrcQ, then r_SrcQ delayed into r_SrcP; edge = r_SrcQ & ~r_SrcP.
REQ-018 Edge-mode source: PEND bit set on edge, held until cleared by PEND W1C (per byte enable) or by a CLAIM read returning that source.
REQ-019 Level-mode source: PEND bit follows r_SrcQ each cycle; W1C and claim have no effect on it.
REQ-020 Set beats clear: edge in same cycle as W1C or claim clear of the same bit leaves bit set.
REQ-021 ENABLE, MODE writes honour byte enables; writes take effect next cycle.
REQ-022 Active = PEND & ENABLE; winner = lowest-index active bit.
REQ-023 FSM states IDLE, CLAIMED; reset to IDLE.
REQ-024 IDLE: o_Irq registered to (Active != 0); CLAIMED: o_Irq = 0.
REQ-025 CLAIM read returns winner+1, or 0 if none; if nonzero, clears winner PEND (edge mode) and goes IDLE->CLAIMED; read returning 0 stays IDLE.
REQ-026 CLAIM read while CLAIMED returns 0, no state change.
REQ-027 Any CLAIM write (any byte enable) in CLAIMED -> IDLE (complete); in IDLE ignored.
REQ-028 STATUS read = {16'b0, 7'b0, state(1=CLAIMED), 2'b0, NUM_SRC[5:0]}.
REQ-029 Latency: first i_Src-high sample at edge k -> PEND readable after edge k+2, o_Irq high after edge k+3 (IDLE, enabled).
REQ-030 Disabling a source or W1C-clearing its pending bit deasserts o_Irq next cycle if no other source active.

Reset
REQ-031 i_Rst_n low asynchronously clears PEND, ENABLE, MODE, r_SrcQ, r_SrcP, sync stages, o_AV_ReadData, o_Irq; FSM to IDLE.
REQ-032 Reset mid-claim discards claim; source already high at release produces no edge.

Configuration
REQ-033 Macro EVENT_IRQ_SYNC_EN defined: two extra flops precede r_SrcQ on each i_Src bit; REQ-029 latencies become k+4 / k+5.
REQ-034 EVENT_IRQ_SYNC_EN undefined: i_Src feeds r_SrcQ directly; i_Src must be synchronous to i_Clk.

Verification
REQ-035 NUM_SRC=8, ENABLE=0x01, edge mode, pulse i_Src[0] one cycle -> PEND=0x01, o_Irq=1 at REQ-029/033 latency.
REQ-036 Sources 2 and 5 pending, ENABLE=0xFF -> CLAIM read=3, PEND=0x20, o_Irq=0; second CLAIM read=0; CLAIM write -> o_Irq=1; CLAIM read=6.
REQ-037 Edge on source 1 same cycle as PEND W1C 0x02 -> PEND bit1 stays 1.
REQ-038 MODE=0x04, hold i_Src[2] high -> PEND bit2=1, W1C 0x04 ineffective; drop i_Src[2] -> PEND bit2=0 after pipeline delay.
REQ-039 Assert i_Rst_n=0 while CLAIMED with PEND=0xFF -> all regs 0, STATUS state=0, o_Irq=0 immediately without clock.
